// File: rtl/btn_event_arbiter.sv
// Debounces N active-low buttons and dispatches press events round-robin over valid/ready.
// Press reaches btn_level ~STABLE_CNT ticks after sync; evt_valid holds with stable evt_id until evt_ready.
module btn_event_arbiter #(
   parameter int N_BTN      = 4,
   parameter int TICK_DIV   = 2000000,
   parameter int STABLE_CNT = 3
) (
   input  logic                     clk,
   input  logic                     rst_n1,
   input  logic [N_BTN-1:0]         btn_raw,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [$clog2(N_BTN)-1:0] evt_id,
   output logic [N_BTN-1:0]         btn_level,
   output logic [N_BTN-1:0]         btn_toggle,
   output logic [N_BTN-1:0]         ovf,
   input  logic                     ovf_clr
);
   localparam int ID_W = $clog2(N_BTN);
   localparam int TW   = $clog2(TICK_DIV);

   typedef enum logic {IDLE, PRESENT} state_t;
   state_t state, state_nxt;

   logic [TW-1:0]    tick_cnt;
   logic             tick;
   logic [N_BTN-1:0] sync1, sync2, s;
   logic [3:0]       stab_cnt [N_BTN];
   logic [3:0]       stab_nxt [N_BTN];
   logic [N_BTN-1:0] level_nxt, press, pending, pending_nxt, clr_mask, ovf_set;
   logic [ID_W-1:0]  last_grant, grant_nxt, id_nxt, pick, cand;
   logic             found, hs;

   assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
   assign s         = ~sync2;
   assign evt_valid = (state == PRESENT);

   // Debounce: a differing sample must repeat STABLE_CNT ticks in a row to be accepted.
   always_comb begin
      level_nxt = btn_level;
      press     = '0;
      for (int i = 0; i < N_BTN; i++) begin
         stab_nxt[i] = stab_cnt[i];
         if (tick) begin
            if (s[i] == btn_level[i]) begin
               stab_nxt[i] = '0;
            end else if (stab_cnt[i] + 4'd1 >= 4'(STABLE_CNT)) begin
               stab_nxt[i]  = '0;
               level_nxt[i] = s[i];
               press[i]     = s[i];
            end else begin
               stab_nxt[i] = stab_cnt[i] + 4'd1;
            end
         end
      end
   end

   // A press landing on the bit being granted re-arms it without counting as overflow.
   always_comb begin
      hs          = (state == PRESENT) && evt_ready;
      clr_mask    = hs ? (N_BTN'(1) << evt_id) : '0;
      ovf_set     = press & pending & ~clr_mask;
      pending_nxt = (pending & ~clr_mask) | press;
   end

   always_comb begin
      found = 1'b0;
      pick  = last_grant;
      cand  = last_grant;
      for (int k = 0; k < N_BTN; k++) begin
         cand = (cand == ID_W'(N_BTN - 1)) ? '0 : cand + ID_W'(1);
         if (!found && pending[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      id_nxt    = evt_id;
      grant_nxt = last_grant;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = PRESENT;
               id_nxt    = pick;
            end
         end
         PRESENT: begin
            if (evt_ready) begin
               state_nxt = IDLE;
               grant_nxt = evt_id;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n1) begin
      if (!rst_n1) begin
         state      <= IDLE;
         evt_id     <= '0;
         last_grant <= ID_W'(N_BTN - 1);
      end else begin
         state      <= state_nxt;
         evt_id     <= id_nxt;
         last_grant <= grant_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n1) begin
      if (!rst_n1) begin
         tick_cnt   <= '0;
         sync1      <= '1;
         sync2      <= '1;
         btn_level  <= '0;
         btn_toggle <= '0;
         pending    <= '0;
         ovf        <= '0;
         for (int i = 0; i < N_BTN; i++) stab_cnt[i] <= '0;
      end else begin
         tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);
         sync1      <= btn_raw;
         sync2      <= sync1;
         btn_level  <= level_nxt;
         btn_toggle <= btn_toggle ^ press;
         pending    <= pending_nxt;
         ovf        <= (ovf_clr ? '0 : ovf) | ovf_set;
         for (int i = 0; i < N_BTN; i++) stab_cnt[i] <= stab_nxt[i];
      end
   end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter; expected evt_id values are queued and checked at each handshake.
`timescale 1ns/1ps
module tb_btn_event_arbiter;
   localparam int N_BTN = 4, TICK_DIV = 4, STABLE_CNT = 3;

   logic       clk = 1'b0;
   logic       rst_n1 = 1'b0;
   logic [3:0] btn_raw = 4'hF;
   logic       evt_ready = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic [3:0] btn_level, btn_toggle, ovf;

   int checks = 0, errors = 0, evt_seen = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   btn_event_arbiter #(.N_BTN(N_BTN), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT)) dut (
      .clk(clk), .rst_n1(rst_n1), .btn_raw(btn_raw),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
      .btn_level(btn_level), .btn_toggle(btn_toggle), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Monitor: every handshake must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n1 && evt_valid && evt_ready) begin
         evt_seen++;
         if (exp_q.size() == 0) check("unexpected_evt", int'(evt_id), -1);
         else check("evt_id", int'(evt_id), exp_q.pop_front());
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_lvl(input logic [3:0] mask, input logic [3:0] want,
                           input int maxc, output int lat);
      lat = 0;
      while ((btn_level & mask) != want && lat < maxc) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      #2;
      rst_n1    = 1'b0;
      btn_raw   = 4'hF;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      #1;
      check({tag, "_valid"},  evt_valid,  0);
      check({tag, "_id"},     evt_id,     0);
      check({tag, "_level"},  btn_level,  0);
      check({tag, "_toggle"}, btn_toggle, 0);
      check({tag, "_ovf"},    ovf,        0);
      tick_n(3);
      rst_n1 = 1'b1;
      tick_n(2);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int lat, n0, viol;
      do_reset("rst0");

      viol = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (evt_valid || btn_level != 0 || btn_toggle != 0 || ovf != 0) viol++;
      end
      check("idle_quiet", viol, 0);
      tick_n(1);

      // Single press, consumer always ready
      evt_ready = 1'b1;
      n0 = evt_seen;
      exp_q.push_back(2);
      btn_raw[2] = 1'b0;
      wait_lvl(4'b0100, 4'b0100, 30, lat);
      check("press_lat_le18", int'(lat <= 18), 1);
      check("press_level", btn_level[2], 1);
      check("press_toggle", btn_toggle[2], 1);
      viol = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (evt_valid) viol++;
      end
      check("valid_pulse_cycles", viol, 1);
      check("press_evt_count", evt_seen - n0, 1);
      tick_n(1);
      n0 = evt_seen;
      btn_raw[2] = 1'b1;
      wait_lvl(4'b0100, 4'b0000, 30, lat);
      check("release_level", btn_level[2], 0);
      tick_n(5);
      check("release_no_evt", evt_seen - n0, 0);
      exp_q.push_back(2);
      btn_raw[2] = 1'b0;
      wait_lvl(4'b0100, 4'b0100, 30, lat);
      check("press2_toggle", btn_toggle[2], 0);
      btn_raw[2] = 1'b1;
      wait_lvl(4'b0100, 4'b0000, 30, lat);
      tick_n(3);

      // Bounce on button 1: never three equal pressed samples in a row
      n0 = evt_seen;
      for (int i = 0; i < 20; i++) begin
         btn_raw[1] = (i % 2 == 1);
         tick_n(3);
      end
      check("bounce_level", btn_level[1], 0);
      check("bounce_no_evt", evt_seen - n0, 0);
      exp_q.push_back(1);
      btn_raw[1] = 1'b0;
      wait_lvl(4'b0010, 4'b0010, 30, lat);
      check("bounce_hold_level", btn_level[1], 1);
      tick_n(5);
      check("bounce_hold_evt", evt_seen - n0, 1);
      btn_raw[1] = 1'b1;
      wait_lvl(4'b0010, 4'b0000, 30, lat);

      // Round-robin from reset priority, then from last_grant = 3
      do_reset("rst1");
      btn_raw = 4'b0100;
      wait_lvl(4'b1011, 4'b1011, 30, lat);
      check("rr_levels", btn_level, 4'b1011);
      tick_n(3);
      check("rr_hold_valid", evt_valid, 1);
      check("rr_hold_id", evt_id, 0);
      n0 = evt_seen;
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(3);
      evt_ready = 1'b1;
      tick_n(10);
      check("rr_count", evt_seen - n0, 3);
      btn_raw = 4'hF;
      wait_lvl(4'b1011, 4'b0000, 30, lat);
      evt_ready = 1'b0;
      btn_raw = 4'b0101;
      wait_lvl(4'b1010, 4'b1010, 30, lat);
      tick_n(3);
      check("rr2_hold_id", evt_id, 1);
      n0 = evt_seen;
      exp_q.push_back(1);
      exp_q.push_back(3);
      evt_ready = 1'b1;
      tick_n(8);
      check("rr2_count", evt_seen - n0, 2);
      btn_raw = 4'hF;
      wait_lvl(4'b1010, 4'b0000, 30, lat);

      // Overflow: two presses while the first is still pending
      do_reset("rst2");
      btn_raw[0] = 1'b0;
      wait_lvl(4'b0001, 4'b0001, 30, lat);
      btn_raw[0] = 1'b1;
      wait_lvl(4'b0001, 4'b0000, 30, lat);
      check("ovf_after_first", ovf[0], 0);
      btn_raw[0] = 1'b0;
      wait_lvl(4'b0001, 4'b0001, 30, lat);
      check("ovf_set", ovf[0], 1);
      check("ovf_toggle", btn_toggle[0], 0);
      btn_raw[0] = 1'b1;
      wait_lvl(4'b0001, 4'b0000, 30, lat);
      check("ovf_valid", evt_valid, 1);
      check("ovf_id", evt_id, 0);
      n0 = evt_seen;
      exp_q.push_back(0);
      evt_ready = 1'b1;
      tick_n(8);
      check("ovf_one_evt", evt_seen - n0, 1);
      check("ovf_sticky", ovf[0], 1);
      ovf_clr = 1'b1;
      tick_n(1);
      check("ovf_cleared", ovf, 0);
      ovf_clr = 1'b0;
      tick_n(2);
      check("ovf_stays_clear", ovf, 0);

      // Reset while an event for button 3 is presented
      evt_ready = 1'b0;
      btn_raw[3] = 1'b0;
      wait_lvl(4'b1000, 4'b1000, 30, lat);
      tick_n(2);
      check("mid_valid", evt_valid, 1);
      check("mid_id", evt_id, 3);
      check("mid_toggle", btn_toggle[3], 1);
      do_reset("rst3");
      n0 = evt_seen;
      evt_ready = 1'b1;
      viol = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (evt_valid) viol++;
      end
      check("post_rst_no_valid", viol, 0);
      check("post_rst_no_evt", evt_seen - n0, 0);
      tick_n(1);
      exp_q.push_back(3);
      btn_raw[3] = 1'b0;
      wait_lvl(4'b1000, 4'b1000, 30, lat);
      tick_n(5);
      check("post_rst_new_evt", evt_seen - n0, 1);
      btn_raw = 4'hF;
      tick_n(20);

      check("sb_drain", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
